// File: rtl/channel_pkg.sv
// rtl/channel_pkg.sv - shared types, field codes and fixed-point helpers for the IIR channel model
package channel_pkg;

    localparam int COEF_MAX_W = 32;

    localparam logic [1:0] CFG_G_R = 2'd0;
    localparam logic [1:0] CFG_G_I = 2'd1;
    localparam logic [1:0] CFG_P_R = 2'd2;
    localparam logic [1:0] CFG_P_I = 2'd3;

    // Coefficients are kept sign-extended so the struct is independent of CW.
    typedef struct packed {
        logic signed [COEF_MAX_W-1:0] g_r;
        logic signed [COEF_MAX_W-1:0] g_i;
        logic signed [COEF_MAX_W-1:0] p_r;
        logic signed [COEF_MAX_W-1:0] p_i;
    } sec_coef_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } state_e;

    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic signed [63:0] rnd_shift(input logic signed [63:0] v, input int frac);
        return (v + (64'sd1 <<< (frac - 1))) >>> frac;
    endfunction

endpackage

// File: rtl/channel_cmac.sv
// rtl/channel_cmac.sv - combinational complex one-pole section update, shared across sections
module channel_cmac
    import channel_pkg::*;
#(
    parameter int DW    = 16,
    parameter int CFRAC = 14,
    parameter int SW    = 24
) (
    input  sec_coef_t       coef,
    input  logic [SW-1:0]   s_r,
    input  logic [SW-1:0]   s_i,
    input  logic [DW-1:0]   x,
    output logic [SW-1:0]   s_r_next,
    output logic [SW-1:0]   s_i_next
);

    logic signed [63:0] sr_w;
    logic signed [63:0] si_w;
    logic signed [63:0] x_w;
    logic signed [63:0] sum_r;
    logic signed [63:0] sum_i;

    // Both components are computed from the old state pair before rounding.
    always_comb begin
        sr_w  = 64'($signed(s_r));
        si_w  = 64'($signed(s_i));
        x_w   = 64'($signed(x));
        sum_r = 64'($signed(coef.p_r)) * sr_w - 64'($signed(coef.p_i)) * si_w
              + 64'($signed(coef.g_r)) * x_w;
        sum_i = 64'($signed(coef.p_i)) * sr_w + 64'($signed(coef.p_r)) * si_w
              + 64'($signed(coef.g_i)) * x_w;
        s_r_next = SW'(sat(rnd_shift(sum_r, CFRAC), SW));
        s_i_next = SW'(sat(rnd_shift(sum_i, CFRAC), SW));
    end

endmodule

// File: rtl/channel_iir_pn.sv
// rtl/channel_iir_pn.sv - programmable pole/residue channel model, sections time-multiplexed on one complex MAC
module channel_iir_pn
    import channel_pkg::*;
#(
    parameter int N_SEC = 6,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int CFRAC = 14,
    parameter int SW    = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DW-1:0]                 x_in,
    input  logic                          x_valid,
    output logic                          x_ready,
    output logic [DW-1:0]                 y_out,
    output logic                          y_valid,
    input  logic                          y_ready,
    input  logic                          bypass,
    input  logic                          cfg_we,
    input  logic [$clog2(4*N_SEC+1)-1:0]  cfg_addr,
    input  logic [CW-1:0]                 cfg_data,
    output logic                          cfg_ready
);

    localparam int AW    = $clog2(4 * N_SEC + 1);
    localparam int ACC_W = SW + $clog2(N_SEC + 1);
    localparam int CNT_W = (N_SEC > 1) ? $clog2(N_SEC) : 1;
    localparam logic [AW-1:0] DC_ADDR = AW'(4 * N_SEC);

    state_e                     state;
    logic [CNT_W-1:0]           cnt;
    logic signed [DW-1:0]       x_lat;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_sum;
    logic signed [SW-1:0]       s_r [N_SEC];
    logic signed [SW-1:0]       s_i [N_SEC];
    sec_coef_t                  coefs [N_SEC];
    logic signed [COEF_MAX_W-1:0] dc;
    logic signed [SW-1:0]       s_r_next;
    logic signed [SW-1:0]       s_i_next;
    logic                       accept;
    logic signed [COEF_MAX_W-1:0] cfg_ext;

    assign x_ready   = (state == IDLE) && !rst;
    assign accept    = x_valid && x_ready;
    assign cfg_ready = x_ready && !x_valid;
    assign y_valid   = (state == OUT);
    assign acc_sum   = acc + ACC_W'(s_r_next);
    assign cfg_ext   = COEF_MAX_W'($signed(cfg_data));

    channel_cmac #(
        .DW    (DW),
        .CFRAC (CFRAC),
        .SW    (SW)
    ) u_cmac (
        .coef     (coefs[cnt]),
        .s_r      (s_r[cnt]),
        .s_i      (s_i[cnt]),
        .x        (x_lat),
        .s_r_next (s_r_next),
        .s_i_next (s_i_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            x_lat <= '0;
            acc   <= '0;
            y_out <= '0;
            dc    <= '0;
            for (int k = 0; k < N_SEC; k++) begin
                s_r[k]   <= '0;
                s_i[k]   <= '0;
                coefs[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_lat <= $signed(x_in);
                        cnt   <= '0;
                        // The direct term seeds the accumulator so sections only add.
                        acc   <= ACC_W'(rnd_shift(64'(dc) * 64'($signed(x_in)), CFRAC));
                        if (bypass) begin
                            y_out <= x_in;
                            state <= OUT;
                        end else begin
                            state <= RUN;
                        end
                    end else if (cfg_we && cfg_ready) begin
                        if (cfg_addr == DC_ADDR) begin
                            dc <= cfg_ext;
                        end else if (cfg_addr < DC_ADDR) begin
                            case (cfg_addr[1:0])
                                CFG_G_R: coefs[cfg_addr[AW-1:2]].g_r <= cfg_ext;
                                CFG_G_I: coefs[cfg_addr[AW-1:2]].g_i <= cfg_ext;
                                CFG_P_R: coefs[cfg_addr[AW-1:2]].p_r <= cfg_ext;
                                CFG_P_I: coefs[cfg_addr[AW-1:2]].p_i <= cfg_ext;
                            endcase
                        end
                    end
                end
                RUN: begin
                    s_r[cnt] <= s_r_next;
                    s_i[cnt] <= s_i_next;
                    acc      <= acc_sum;
                    if (cnt == CNT_W'(N_SEC - 1)) begin
                        y_out <= DW'(sat(64'(acc_sum), DW));
                        state <= OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (y_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_iir_pn.sv
// tb/tb_channel_iir_pn.sv - scoreboard bench for channel_iir_pn with directed impulse vectors
module tb_channel_iir_pn;

    localparam int N_SEC = 6;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int AW    = $clog2(4 * N_SEC + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] x_in = '0;
    logic          x_valid = 1'b0;
    logic          x_ready;
    logic [DW-1:0] y_out;
    logic          y_valid;
    logic          y_ready = 1'b1;
    logic          bypass = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [CW-1:0] cfg_data = '0;
    logic          cfg_ready;

    int errors = 0;
    int checks = 0;
    int xfers  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    channel_iir_pn #(
        .N_SEC (N_SEC),
        .DW    (DW),
        .CW    (CW),
        .CFRAC (14),
        .SW    (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .bypass    (bypass),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && y_valid && y_ready) begin
            xfers++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL y_unexpected: got %0d expected no output", $signed(y_out));
            end else begin
                check("y_out", int'($signed(y_out)), exp_q.pop_front());
            end
        end
    end

    task automatic reset_dut();
        rst = 1'b1; x_valid = 1'b0; cfg_we = 1'b0; bypass = 1'b0; y_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input int data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = CW'(data);
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic send(input int x, input bit byp, input bit expect_out, input int exp_y);
        int n = 0;
        @(negedge clk);
        while (!x_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!x_ready) begin
            checks++;
            errors++;
            $display("FAIL x_ready_timeout: got 0 expected 1");
            return;
        end
        x_valid = 1'b1; x_in = DW'(x); bypass = byp;
        if (expect_out) exp_q.push_back(exp_y);
        @(posedge clk);
        #1 x_valid = 1'b0; bypass = 1'b0;
    endtask

    task automatic measure(output int n);
        n = 0;
        while (!y_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int bad;
        int base;
        int held;
        int imp1[5] = '{1024, 512, 256, 128, 64};
        int imp2[6] = '{1000, 0, -1000, 0, 1000, 0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_x_ready", int'(x_ready), 0);
        check("rst_y_valid", int'(y_valid), 0);
        check("rst_y_out", int'(y_out), 0);
        rst = 1'b0;
        #1 check("post_rst_x_ready", int'(x_ready), 1);

        // real pole, plus latency and bypass timing
        cfg_write(0, 16384);
        cfg_write(2, 8192);
        send(1024, 1'b0, 1'b1, imp1[0]);
        measure(lat);
        check("latency", lat, N_SEC);
        for (int i = 1; i < 5; i++) send(0, 1'b0, 1'b1, imp1[i]);
        drain();
        send(777, 1'b1, 1'b1, 777);
        measure(lat);
        check("bypass_latency", lat, 0);
        send(0, 1'b0, 1'b1, 32);
        drain();

        // rotation
        reset_dut();
        cfg_write(0, 16384);
        cfg_write(3, 16384);
        for (int i = 0; i < 6; i++) send((i == 0) ? 1000 : 0, 1'b0, 1'b1, imp2[i]);
        drain();

        // saturation through dc
        reset_dut();
        cfg_write(4 * N_SEC, 32767);
        send(32767, 1'b0, 1'b1, 32767);
        send(-32768, 1'b0, 1'b1, -32768);
        send(100, 1'b0, 1'b1, 200);
        drain();

        // backpressure
        y_ready = 1'b0;
        send(10, 1'b0, 1'b1, 20);
        measure(lat);
        held = int'($signed(y_out));
        check("bp_value", held, 20);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!y_valid || int'($signed(y_out)) != held || x_ready) bad++;
        end
        check("bp_stable", bad, 0);
        base = xfers;
        @(posedge clk);
        #1 y_ready = 1'b1;
        @(posedge clk);
        #1 check("bp_next_accept", int'(x_ready), 1);
        repeat (3) @(negedge clk);
        check("bp_one_xfer", xfers - base, 1);
        drain();

        // cfg dropped during RUN, then reset mid-RUN
        reset_dut();
        cfg_write(0, 16384);
        cfg_write(2, 8192);
        send(1024, 1'b0, 1'b1, 1024);
        cfg_we = 1'b1; cfg_addr = AW'(2); cfg_data = CW'(16384);
        check("cfg_ready_run", int'(cfg_ready), 0);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        send(0, 1'b0, 1'b1, 512);
        send(0, 1'b0, 1'b1, 256);
        drain();
        send(0, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (y_valid) bad++;
        end
        check("abort_no_y", bad, 0);
        send(1024, 1'b0, 1'b1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
